// File: rtl/clk_div_scheduler.sv
// Slot-table sequencer for the /2, /3, /4, /8 clock divider: drives the divider
// select and a tick enable, and changes the select only on a tick boundary.
module clk_div_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2,
    parameter int DWELL_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [SLOT_W-1:0]  cfg_addr,
    input  logic [1:0]         cfg_sel,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    output logic [1:0]         sel_out,
    output logic               tick,
    output logic [SLOT_W-1:0]  cur_slot,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    state_t             state;
    logic [1:0]         tbl_sel   [NUM_SLOTS];
    logic [DWELL_W-1:0] tbl_dwell [NUM_SLOTS];
    logic [2:0]         ph;
    logic [DWELL_W-1:0] tcnt;
    logic               loop_q;
    logic               stop_q;

    logic               abort_now;
    logic               slot_done;
    logic [SLOT_W-1:0]  next_slot;
    logic [1:0]         first_sel;

    // Terminal phase value for each select code, i.e. divisor minus one.
    function automatic logic [2:0] last_phase(input logic [1:0] sel);
        case (sel)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    assign tick      = (state == RUN) && (ph == last_phase(sel_out));
    assign busy      = (state == RUN);
    assign abort_now = stop_q || stop;
    assign slot_done = (tcnt == tbl_dwell[cur_slot]);
    assign next_slot = cur_slot + SLOT_W'(1);
    // A write landing in the same cycle as start must be seen by slot 0.
    assign first_sel = (cfg_wr && (cfg_addr == '0)) ? cfg_sel : tbl_sel[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= '0;
            tcnt     <= '0;
            loop_q   <= 1'b0;
            stop_q   <= 1'b0;
            sel_out  <= '0;
            cur_slot <= '0;
            done     <= 1'b0;
            // NOTE: the table is reset on purpose -- a cleared table after reset
            // is visible behaviour, so this storage is not a plain RAM.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl_sel[i]   <= '0;
                tbl_dwell[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read above
            // sees the pre-edge value regardless of statement order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_wr) begin
                        tbl_sel[cfg_addr]   <= cfg_sel;
                        tbl_dwell[cfg_addr] <= cfg_dwell;
                    end
                    if (start) begin
                        state    <= RUN;
                        cur_slot <= '0;
                        sel_out  <= first_sel;
                        ph       <= '0;
                        tcnt     <= '0;
                        loop_q   <= loop;
                        stop_q   <= 1'b0;
                    end
                end

                RUN: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (!tick) begin
                        ph <= ph + 3'd1;
                    end else begin
                        ph <= '0;
                        if (!abort_now && !slot_done) begin
                            tcnt <= tcnt + DWELL_W'(1);
                        end else begin
                            tcnt <= '0;
                            if (abort_now) begin
                                state  <= IDLE;
                                stop_q <= 1'b0;
                                done   <= 1'b1;
                            end else if (cur_slot != LAST_SLOT) begin
                                cur_slot <= next_slot;
                                sel_out  <= tbl_sel[next_slot];
                            end else if (loop_q) begin
                                cur_slot <= '0;
                                sel_out  <= tbl_sel[0];
                            end else begin
                                state  <= IDLE;
                                stop_q <= 1'b0;
                                done   <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Scoreboard bench for clk_div_scheduler: an event-list model of each run feeds a
// queue that a negedge monitor drains on every tick or done pulse.
module tb_clk_div_scheduler;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int DWELL_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_wr = 1'b0;
    logic [SLOT_W-1:0]  cfg_addr = '0;
    logic [1:0]         cfg_sel = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic               loop = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [1:0]         sel_out;
    logic               tick;
    logic [SLOT_W-1:0]  cur_slot;
    logic               busy;
    logic               done;

    clk_div_scheduler #(
        .NUM_SLOTS(NUM_SLOTS),
        .SLOT_W   (SLOT_W),
        .DWELL_W  (DWELL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_wr   (cfg_wr),
        .cfg_addr (cfg_addr),
        .cfg_sel  (cfg_sel),
        .cfg_dwell(cfg_dwell),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .sel_out  (sel_out),
        .tick     (tick),
        .cur_slot (cur_slot),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [1:0] sel;
        int         slot;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Model of the table contents as the bench has written them.
    int m_sel   [NUM_SLOTS];
    int m_dwell [NUM_SLOTS];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    endtask

    function automatic logic [63:0] pack(input int c, input logic d, input logic t,
                                         input logic b, input logic [1:0] s, input int sl);
        return {c[31:0], 4'(d), 4'(t), 4'(b), 4'(s), 8'(sl), 8'h00};
    endfunction

    function automatic int divisor(input int sel);
        return (sel == 3) ? 8 : sel + 2;
    endfunction

    // Walk the table as a list of whole periods; return the done cycle relative to start.
    task automatic model(input bit lp, input int stop_rel, input int base, output int done_rel);
        int  t   = 0;
        int  s   = 0;
        bit  fin = 1'b0;
        ev_t e;
        while (!fin) begin
            for (int j = 0; j <= m_dwell[s]; j++) begin
                t += divisor(m_sel[s]);
                e.cyc = base + t; e.is_done = 1'b0; e.sel = 2'(m_sel[s]); e.slot = s;
                exp_q.push_back(e);
                if (stop_rel > 0 && t >= stop_rel) begin
                    fin = 1'b1;
                    break;
                end
            end
            if (!fin) begin
                if (s == NUM_SLOTS - 1) begin
                    if (lp) s = 0;
                    else fin = 1'b1;
                end else begin
                    s++;
                end
            end
        end
        done_rel = t + 1;
        e.cyc = base + done_rel; e.is_done = 1'b1; e.sel = 2'(m_sel[s]); e.slot = s;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (tick === 1'b1 || done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", pack(cyc, done, tick, busy, sel_out, int'(cur_slot)), 64'h0);
            end else begin
                e = exp_q.pop_front();
                check(e.is_done ? "done_event" : "tick_event",
                      pack(cyc, done, tick, busy, sel_out, int'(cur_slot)),
                      pack(e.cyc, e.is_done, !e.is_done, !e.is_done, e.sel, e.slot));
            end
        end
    end

    task automatic write_slot(input int a, input int s, input int d);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = SLOT_W'(a); cfg_sel = 2'(s); cfg_dwell = DWELL_W'(d);
        m_sel[a] = s; m_dwell[a] = d;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic load_table_a();
        write_slot(0, 0, 1);
        write_slot(1, 1, 0);
        write_slot(2, 3, 0);
        write_slot(3, 2, 2);
    endtask

    // One sequence: start, optional same-cycle write, stop pulse, RUN-time noise, reset.
    task automatic run(input bit lp, input int stop_rel, input bit noise,
                       input bit same_wr, input int wa, input int ws, input int wd,
                       input int rst_at);
        int base;
        int done_rel;
        int last_rel;
        @(negedge clk);
        base  = cyc;
        start = 1'b1;
        loop  = lp;
        if (same_wr) begin
            cfg_wr = 1'b1; cfg_addr = SLOT_W'(wa); cfg_sel = 2'(ws); cfg_dwell = DWELL_W'(wd);
            m_sel[wa] = ws; m_dwell[wa] = wd;
        end
        model(lp, stop_rel, base, done_rel);
        if (rst_at > 0) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > base + rst_at) void'(exp_q.pop_back());
        end
        last_rel = (rst_at > 0) ? rst_at + 1 : done_rel + 1;
        for (int rel = 1; rel <= last_rel; rel++) begin
            @(negedge clk);
            start  = 1'b0;
            cfg_wr = 1'b0;
            stop   = (rel == stop_rel);
            if (noise && rel < done_rel) begin
                if ($urandom_range(7) == 0) begin
                    cfg_wr    = 1'b1;
                    cfg_addr  = SLOT_W'($urandom_range(NUM_SLOTS - 1));
                    cfg_sel   = 2'($urandom_range(3));
                    cfg_dwell = DWELL_W'($urandom_range(15));
                end
                start = ($urandom_range(15) == 0);
                loop  = 1'($urandom_range(1));
            end
            if (rst_at > 0 && rel == rst_at) rst_n = 1'b0;
            if (rst_at > 0 && rel == rst_at + 1) begin
                check("reset_mid_run", {59'h0, tick, busy, done, sel_out} | 64'(cur_slot), 64'h0);
                rst_n = 1'b1;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    m_sel[i] = 0; m_dwell[i] = 0;
                end
            end
        end
        stop = 1'b0;
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_sel[i] = 0; m_dwell[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {59'h0, tick, busy, done, sel_out} | 64'(cur_slot), 64'h0);
        rst_n = 1'b1;

        load_table_a();
        run(1'b0, 0,  1'b0, 1'b0, 0, 0, 0, 0);   // plain pass, done at 28
        run(1'b1, 40, 1'b0, 1'b0, 0, 0, 0, 0);   // wraps to slot 0, stopped on slot 2
        run(1'b1, 9,  1'b0, 1'b0, 0, 0, 0, 0);   // stop during the /8 slot
        run(1'b0, 0,  1'b1, 1'b0, 0, 0, 0, 0);   // RUN-time writes/starts ignored
        run(1'b0, 0,  1'b0, 1'b0, 0, 0, 0, 0);   // table still intact
        run(1'b0, 0,  1'b0, 1'b1, 1, 3, 0, 0);   // same-cycle write: slot 1 runs /8
        run(1'b0, 7,  1'b0, 1'b0, 0, 0, 0, 0);   // stop sampled on a tick cycle

        for (int i = 0; i < NUM_SLOTS; i++) write_slot(i, 1, 15);
        run(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);    // 64 ticks, done at 193

        load_table_a();
        run(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 10);   // reset at cycle 10
        run(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);    // cleared table, done at 9

        for (int n = 0; n < 25; n++) begin
            int  nw;
            bit  lp;
            int  sr;
            nw = $urandom_range(NUM_SLOTS);
            for (int w = 0; w < nw; w++)
                write_slot($urandom_range(NUM_SLOTS - 1), $urandom_range(3), $urandom_range(15));
            lp = 1'($urandom_range(1));
            if (lp) sr = $urandom_range(700, 1);
            else sr = ($urandom_range(1) == 1) ? $urandom_range(300, 1) : 0;
            run(lp, sr, 1'b1, 1'($urandom_range(1)), $urandom_range(NUM_SLOTS - 1),
                $urandom_range(3), $urandom_range(15), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_scheduler.md
Name: clk_div_scheduler

Overview:
Programmable sequencer for the divide-by-2/3/4/8 clock divider. It steps through a small table of slots. Each slot holds a divider select code and a dwell count. The block drives the divider's sel input and emits a one-cycle tick enable at the selected rate. It switches selection only on a tick boundary, so the downstream logic never sees a truncated divided period.

Parameters:
NUM_SLOTS, 4, number of table slots (power of two, 2..8)
SLOT_W, 2, log2(NUM_SLOTS)
DWELL_W, 4, width of per-slot dwell field; ticks per slot = dwell+1

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
cfg_wr  in  1  table write strobe
cfg_addr  in  SLOT_W  slot index to write
cfg_sel  in  2  divider code: 00=/2, 01=/3, 10=/4, 11=/8
cfg_dwell  in  DWELL_W  dwell field
loop  in  1  1 = wrap after last slot; 0 = stop after last slot (sampled at start)
start  in  1  begin sequence at slot 0 (IDLE only)
stop  in  1  request graceful abort (RUN only)
sel_out  out  2  current divider code, to the divider's sel input
tick  out  1  one-cycle enable at the end of each divided period
cur_slot  out  SLOT_W  slot being executed
busy  out  1  high in RUN
done  out  1  one-cycle pulse when the sequence ends

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all table entries sel=00, dwell=0; ph=0, tcnt=0, loop_q=0, stop_q=0; sel_out=00, cur_slot=0, tick=0, busy=0, done=0. Reset during RUN aborts immediately with no done pulse.
- Divisor N(sel): 00→2, 01→3, 10→4, 11→8. The phase counter ph is 3 bits and counts 0..N-1.
- States: IDLE, RUN.
- IDLE:
  - cfg_wr writes table[cfg_addr] at the edge.
  - start=1 → RUN next cycle: cur_slot=0, sel_out=table[0].sel, ph=0, tcnt=0, loop_q=loop.
  - A cfg_wr and start in the same cycle: the write is applied first, and the run uses the new value.
  - stop is ignored.
- RUN, each cycle:
  - tick = (ph==N(sel_out)-1). tick is a combinational decode of registers and is 0 outside RUN.
  - Non-tick cycle: ph+1.
  - Tick with tcnt<dwell: ph=0, tcnt+1.
  - Tick with tcnt==dwell (slot complete), or tick with stop_q=1: ph=0, tcnt=0, then one of:
    - stop_q=1 → IDLE.
    - cur_slot<NUM_SLOTS-1 → cur_slot+1, sel_out=table[next].sel.
    - Last slot with loop_q=1 → cur_slot=0, sel_out=table[0].sel.
    - Last slot with loop_q=0 → IDLE.
- sel_out changes only on the edge following a tick, so a slot always runs whole periods.
- Latency: first tick occurs N cycles after the start edge (first RUN cycle counts as 1).
- stop: sets stop_q on any RUN cycle. The abort takes effect at the next tick, including a tick in the same cycle that stop is first sampled. stop_q clears on entering IDLE.
- done: high for exactly the first IDLE cycle after a RUN exit (normal or stop).
- busy = (state==RUN). On exit, sel_out and cur_slot hold their last values.
- Writes in RUN: cfg_wr is ignored, and the table is unchanged.
- start in RUN: ignored, no restart.
- dwell at maximum (2^DWELL_W-1): 2^DWELL_W ticks; tcnt must not wrap early.

Test Plan:
- Table {0:sel00 d1, 1:sel01 d0, 2:sel11 d0, 3:sel10 d2}, loop=0, start at edge 0 → ticks at cycles 2,4,7,15,19,23,27; sel_out 00→01 at 5, →11 at 8, →10 at 16; busy low and done=1 at cycle 28 only.
- Same table, loop=1 → after the tick at 27, cur_slot=0, sel_out=00, next tick at 29; busy stays high.
- Loop run, stop pulsed at cycle 9 (slot 2, /8) → no more ticks after cycle 15; IDLE and done at 16; sel_out stays 11.
- cfg_wr to slot 1 with sel=11 during RUN → table unchanged; slot 1 still runs /3. The same write in IDLE together with start → slot 1 runs /8.
- All slots sel=01, dwell=15, loop=0 → exactly 64 ticks spaced 3 cycles apart; done at cycle 193.
- rst_n=0 at cycle 10 of a run → next cycle: tick=0, busy=0, sel_out=00, cur_slot=0, done=0; table cleared (start then runs /2 with 1 tick per slot, done at cycle 9).
